// File: rtl/io_input_pkg.sv
// Shared constants and types for the CPU input-port controller:
// read-map word indices and the per-port debounce state encoding.
package io_input_pkg;

  localparam logic [5:0] IO_W_PORT0  = 6'd0;
  localparam logic [5:0] IO_W_PORT1  = 6'd1;
  localparam logic [5:0] IO_W_STATUS = 6'd2;
  localparam logic [5:0] IO_W_ARM    = 6'd3;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_e;

endpackage

// File: rtl/io_debounce.sv
// One input port: 2-FF synchroniser, tick-driven debounce FSM, committed value.
// Ports: i_clk, i_reset (sync, active-high), i_tick, i_raw -> o_value, o_commit (pulse).
module io_debounce #(
  parameter int WIDTH    = 5,
  parameter int DEBOUNCE = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_value,
  output logic             o_commit
);
  import io_input_pkg::*;

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  db_state_e        r_state;
  db_state_e        w_state_d;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_value;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_cand_d;
  logic [WIDTH-1:0] w_value_d;
  logic [CW-1:0]    w_cnt_d;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_commit;
  logic [WIDTH-1:0] w_s;

  assign w_s = r_sync2;
  // Saturating so the count can never wrap back below DEBOUNCE.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_cnt_d   = r_cnt;
    w_value_d = r_value;
    w_commit  = 1'b0;
    if (i_tick) begin
      case (r_state)
        DB_STABLE: begin
          if (w_s != r_value) begin
            w_cand_d = w_s;
            w_cnt_d  = CNT_ONE;
            if (DEBOUNCE == 1) begin
              w_value_d = w_s;
              w_commit  = 1'b1;
            end else begin
              w_state_d = DB_CHECK;
            end
          end
        end
        DB_CHECK: begin
          if (w_s != r_cand) begin
            // Returning to the committed value drops the glitch.
            if (w_s == r_value) begin
              w_state_d = DB_STABLE;
            end else begin
              w_cand_d = w_s;
              w_cnt_d  = CNT_ONE;
            end
          end else begin
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
              w_value_d = r_cand;
              w_commit  = 1'b1;
              w_state_d = DB_STABLE;
            end
          end
        end
        default: w_state_d = DB_STABLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= DB_STABLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_state_d;
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cand  <= w_cand_d;
      r_cnt   <= w_cnt_d;
      r_value <= w_value_d;
    end
  end

  assign o_value  = r_value;
  assign o_commit = w_commit;

endmodule

// File: rtl/io_input_ctrl.sv
// CPU input-port controller: shared sample prescaler, two debounced ports,
// change flags with read-to-clear, irq arm and combinational read mux.
// Ports: io_clk, reset, addr, rd_en, in_port0/1 -> io_read_data, irq.
module io_input_ctrl #(
  parameter int WIDTH    = 5,
  parameter int TICK_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] io_read_data,
  output logic        irq
);
  import io_input_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [1:0]       r_chg;
  logic             r_irq_en;
  logic             w_tick;
  logic [5:0]       w_word;
  logic             w_clr;
  logic             w_arm;
  logic [WIDTH-1:0] w_val0;
  logic [WIDTH-1:0] w_val1;
  logic             w_commit0;
  logic             w_commit1;
  logic             w_unused;

  assign w_unused = &{1'b0, addr[31:8], addr[1:0],
                      in_port0[31:WIDTH], in_port1[31:WIDTH]};

  assign w_tick = (r_presc == P_LAST);
  assign w_word = addr[7:2];
  assign w_clr  = rd_en && (w_word == IO_W_STATUS);
  assign w_arm  = rd_en && (w_word == IO_W_ARM);

  always_ff @(posedge io_clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  io_debounce #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_db0 (
    .i_clk    (io_clk),
    .i_reset  (reset),
    .i_tick   (w_tick),
    .i_raw    (in_port0[WIDTH-1:0]),
    .o_value  (w_val0),
    .o_commit (w_commit0)
  );

  io_debounce #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_db1 (
    .i_clk    (io_clk),
    .i_reset  (reset),
    .i_tick   (w_tick),
    .i_raw    (in_port1[WIDTH-1:0]),
    .o_value  (w_val1),
    .o_commit (w_commit1)
  );

  // A commit landing on the clearing edge keeps its flag.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      r_chg    <= '0;
      r_irq_en <= 1'b0;
    end else begin
      r_chg    <= (r_chg & ~{2{w_clr}}) | {w_commit1, w_commit0};
      r_irq_en <= r_irq_en | w_arm;
    end
  end

  always_comb begin
    io_read_data = '0;
    unique case (1'b1)
      (w_word == IO_W_PORT0):  io_read_data[WIDTH-1:0] = w_val0;
      (w_word == IO_W_PORT1):  io_read_data[WIDTH-1:0] = w_val1;
      (w_word == IO_W_STATUS): io_read_data[2:0] = {r_irq_en, r_chg};
      default:                 io_read_data = '0;
    endcase
  end

  assign irq = r_irq_en & (|r_chg);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed + randomized bench for io_input_ctrl against a
// tick/run-length reference model (TICK_DIV=4, DEBOUNCE=3, WIDTH=5).
module tb_io_input_ctrl;
  localparam int W  = 5;
  localparam int TD = 4;
  localparam int DB = 3;

  logic        io_clk   = 1'b0;
  logic        reset    = 1'b1;
  logic        rd_en    = 1'b0;
  logic [31:0] addr     = '0;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  wire  [31:0] io_read_data;
  wire         irq;

  always #5 io_clk = ~io_clk;

  io_input_ctrl #(.WIDTH(W), .TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .io_clk       (io_clk),
    .reset        (reset),
    .addr         (addr),
    .rd_en        (rd_en),
    .in_port0     (in_port0),
    .in_port1     (in_port1),
    .io_read_data (io_read_data),
    .irq          (irq)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_s1 [2];
  logic [W-1:0] m_s2 [2];
  logic [W-1:0] m_reg [2];
  logic [W-1:0] m_last [2];
  int           m_run [2];
  int           m_pc;
  logic [1:0]   m_chg;
  logic         m_irqen;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    if (w == 6'd0) return {27'b0, m_reg[0]};
    if (w == 6'd1) return {27'b0, m_reg[1]};
    if (w == 6'd2) return {29'b0, m_irqen, m_chg};
    return 32'h0;
  endfunction

  function automatic logic m_irq();
    return m_irqen & (|m_chg);
  endfunction

  // A port commits when DB consecutive tick samples agree on a new value.
  function automatic logic m_commit_next(input int p);
    logic [W-1:0] s;
    int r;
    if (reset || m_pc != TD - 1) return 1'b0;
    s = m_s2[p];
    r = (s == m_last[p]) ? m_run[p] + 1 : 1;
    return (r >= DB) && (s != m_reg[p]);
  endfunction

  task automatic m_edge();
    logic [W-1:0] raw [2];
    logic cm [2];
    logic tick, clr, arm;
    logic [W-1:0] s;
    int r;
    raw[0] = in_port0[W-1:0];
    raw[1] = in_port1[W-1:0];
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_s1[p] = '0; m_s2[p] = '0; m_reg[p] = '0;
        m_last[p] = '0; m_run[p] = 0;
      end
      m_chg = '0; m_irqen = 1'b0; m_pc = 0;
    end else begin
      tick = (m_pc == TD - 1);
      clr  = rd_en && (addr[7:2] == 6'd2);
      arm  = rd_en && (addr[7:2] == 6'd3);
      for (int p = 0; p < 2; p++) begin
        cm[p] = m_commit_next(p);
        if (tick) begin
          s = m_s2[p];
          r = (s == m_last[p]) ? m_run[p] + 1 : 1;
          if (r > DB) r = DB;
          if (cm[p]) m_reg[p] = s;
          m_last[p] = s;
          m_run[p]  = r;
        end
        m_s2[p] = m_s1[p];
        m_s1[p] = raw[p];
      end
      m_chg   = (m_chg & {~clr, ~clr}) | {cm[1], cm[0]};
      m_irqen = m_irqen | arm;
      m_pc    = tick ? 0 : m_pc + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    #1;
    chk("rdata", io_read_data, m_read(addr));
    chk("irq", {31'b0, irq}, {31'b0, m_irq()});
    m_edge();
    @(posedge io_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    addr  = a;
    rd_en = 1'b0;
    #1;
    chk(tag, io_read_data, exp);
  endtask

  task automatic clear_chg();
    addr  = 32'h8;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  logic        found;
  logic [31:0] r;
  int          hold0, hold1;

  initial begin
    // 1. reset with a live input
    reset    = 1'b1;
    in_port0 = 32'h1F;
    m_edge(); @(posedge io_clk); #1;
    m_edge(); @(posedge io_clk); #1;
    rd(32'h0, 32'h0, "t1_rst_w0");
    rd(32'h4, 32'h0, "t1_rst_w1");
    rd(32'h8, 32'h0, "t1_rst_w2");
    chk("t1_rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    addr  = 32'h0;
    steps(18);
    rd(32'h0, 32'h1F, "t1_word0");
    rd(32'h8, 32'h1, "t1_status");

    // 2. one-tick glitch on port1
    clear_chg();
    in_port1 = 32'h0A;
    steps(4);
    in_port1 = 32'h0;
    steps(16);
    rd(32'h4, 32'h0, "t2_word1");
    rd(32'h8, 32'h0, "t2_status");

    // 3. bounce 3,4,3 then hold 4
    in_port0 = 32'h3; steps(4);
    in_port0 = 32'h4; steps(4);
    in_port0 = 32'h3; steps(4);
    rd(32'h0, 32'h1F, "t3_no_early");
    in_port0 = 32'h4;
    steps(16);
    rd(32'h0, 32'h4, "t3_word0");
    rd(32'h8, 32'h1, "t3_one_chg");

    // 4. read-clear on the commit edge
    clear_chg();
    in_port1 = 32'h15;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_commit_next(1)) begin found = 1'b1; break; end
      step();
    end
    chk("t4_bound", {31'b0, found}, 32'h1);
    addr  = 32'h8;
    rd_en = 1'b1;
    #1;
    chk("t4_old_status", io_read_data, 32'h0);
    step();
    rd_en = 1'b0;
    rd(32'h8, 32'h2, "t4_set_wins");
    rd(32'h4, 32'h15, "t4_word1");

    // 5. irq arm, rise, fall
    clear_chg();
    addr  = 32'hC;
    rd_en = 1'b1;
    step();
    rd(32'hC, 32'h0, "t5_w3_zero");
    rd(32'h8, 32'h4, "t5_armed");
    in_port0 = 32'h0C;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_commit_next(0)) begin found = 1'b1; break; end
      step();
    end
    chk("t5_bound", {31'b0, found}, 32'h1);
    chk("t5_irq_pre", {31'b0, irq}, 32'h0);
    step();
    chk("t5_irq_rise", {31'b0, irq}, 32'h1);
    clear_chg();
    chk("t5_irq_fall", {31'b0, irq}, 32'h0);

    // reset mid-debounce, then recommit
    in_port1 = 32'h07;
    addr = 32'h4;
    steps(9);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    rd(32'h4, 32'h0, "t7_w1_reset");
    rd(32'h0, 32'h0, "t7_w0_reset");
    rd(32'h8, 32'h0, "t7_status");
    addr = 32'h4;
    steps(18);
    rd(32'h4, 32'h07, "t7_recommit");

    // 6. width masking, both ports committing together
    clear_chg();
    in_port0 = 32'hFFFF_FFE3;
    in_port1 = 32'hFFFF_FFF1;
    addr = 32'h0;
    steps(20);
    rd(32'h0, 32'h3, "t6_word0");
    rd(32'h4, 32'h11, "t6_word1");
    rd(32'h8, 32'h3, "t6_both_chg");

    // randomized traffic against the model
    hold0 = 0;
    hold1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold0 == 0) begin
        in_port0 = $urandom;
        hold0 = $urandom_range(1, 16);
      end
      if (hold1 == 0) begin
        in_port1 = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        hold1 = $urandom_range(1, 16);
      end
      hold0--;
      hold1--;
      r = $urandom;
      addr  = {r[31:8], 6'($urandom_range(0, 5)), r[1:0]};
      rd_en = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    rd_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
